multicycle_control: RTL and testbench

- Control FSM for the multi-cycle RV32I datapath variant.
- It is the producer side of the ALU interface: it drives alu_control and the operand selects into the existing ALU, and consumes the ALU zero flag for branches.
- It sequences fetch, decode, execute, memory and writeback phases.
- It handshakes with a single shared instruction/data memory port.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// ILLEGAL_TRAP_EN adds the TRAP state used for unknown opcodes.
package riscv_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0100,
    ALU_XOR  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_SLTU = 4'b1100,
    ALU_SLT  = 4'b1101
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory bundle: instruction fields and flags in,
// strobes and mux selects out. The controller uses the master modport.
interface multicycle_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic                  adr_src;
  logic                  ir_write;
  logic                  pc_write;
  logic                  reg_write;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode to the ALU operation code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control
);

  logic w_rtype;
  assign w_rtype = (i_opcode == OP_RTYPE);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_funct3)
      3'b000: o_alu_control = (w_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: o_alu_control = ALU_SLL;
      3'b010: o_alu_control = ALU_SLT;
      3'b011: o_alu_control = ALU_SLTU;
      3'b100: o_alu_control = ALU_XOR;
      // shifts keep funct7b5 for both R and I forms (SRAI vs SRLI)
      3'b101: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: o_alu_control = ALU_OR;
      3'b111: o_alu_control = ALU_AND;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_e     r_state, w_state_next;
  logic [3:0] w_dec_alu;
  logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
  logic       w_illegal;
  logic [1:0] w_src_a, w_src_b, w_result_src;
  logic [2:0] w_imm_src;
  logic [3:0] w_alu;

  alu_decoder u_alu_decoder (
    .i_opcode      (bus.opcode),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .o_alu_control (w_dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_src_a      = SRC_A_PC;
    w_src_b      = SRC_B_RS2;
    w_result_src = RES_ALUOUT;
    w_imm_src    = IMM_I;
    w_alu        = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_src_b      = SRC_B_FOUR;
        w_result_src = RES_ALU;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures oldPC + imm as the branch/jump target
        w_src_a = SRC_A_OLDPC;
        w_src_b = SRC_B_IMM;
        case (bus.opcode)
          OP_LOAD:   begin w_imm_src = IMM_I; w_state_next = S_MEMADR; end
          OP_STORE:  begin w_imm_src = IMM_S; w_state_next = S_MEMADR; end
          OP_RTYPE:  w_state_next = S_EXECR;
          OP_ITYPE:  w_state_next = S_EXECI;
          OP_BRANCH: begin w_imm_src = IMM_B; w_state_next = S_BRANCH; end
          OP_JAL:    begin w_imm_src = IMM_J; w_state_next = S_JAL; end
`ifdef ILLEGAL_TRAP_EN
          default:   w_state_next = S_TRAP;
`else
          default:   w_state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_src_a      = SRC_A_RS1;
        w_src_b      = SRC_B_IMM;
        w_state_next = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_state_next = S_FETCH;
      end
      S_EXECR: begin
        w_src_a      = SRC_A_RS1;
        w_alu        = w_dec_alu;
        w_state_next = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a      = SRC_A_RS1;
        w_src_b      = SRC_B_IMM;
        w_alu        = w_dec_alu;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a = SRC_A_RS1;
        w_alu   = ALU_SUB;
        case (bus.funct3)
          3'b000:  w_pc_write = bus.zero;
          3'b001:  w_pc_write = ~bus.zero;
          default: w_pc_write = 1'b0;
        endcase
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        w_src_a      = SRC_A_OLDPC;
        w_src_b      = SRC_B_FOUR;
        w_pc_write   = 1'b1;
        w_state_next = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_illegal    = 1'b1;
        w_state_next = S_TRAP;
      end
`endif
      default: w_state_next = S_FETCH;
    endcase
    // reset forces a quiet bus in the same cycle, aborting any request
    if (rst) begin
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_illegal    = 1'b0;
      w_src_a      = SRC_A_PC;
      w_src_b      = SRC_B_RS2;
      w_result_src = RES_ALUOUT;
      w_imm_src    = IMM_I;
      w_alu        = ALU_ADD;
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.adr_src     = w_adr_src;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_src_a   = w_src_a;
  assign bus.alu_src_b   = w_src_b;
  assign bus.result_src  = w_result_src;
  assign bus.imm_src     = w_imm_src;
  assign bus.alu_control = ALU_CTRL_W'(w_alu);
  assign bus.illegal     = w_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle expectations built from
// the instruction class, random memory waits, compared every cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_CTRL_W(4)) bus ();
  multicycle_control #(.ALU_CTRL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       req, we, adr, ir, pcw, rw;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic  ready;
    logic  zero;
    outs_t o;
  } cyc_t;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  cyc_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic outs_t sample();
    outs_t s;
    s.req = bus.mem_req;   s.we  = bus.mem_we;    s.adr = bus.adr_src;
    s.ir  = bus.ir_write;  s.pcw = bus.pc_write;  s.rw  = bus.reg_write;
    s.sa  = bus.alu_src_a; s.sb  = bus.alu_src_b; s.rs  = bus.result_src;
    s.imm = bus.imm_src;   s.alu = bus.alu_control; s.ill = bus.illegal;
    return s;
  endfunction

  task automatic check(string tag, outs_t got, outs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU op from the instruction's mnemonic meaning.
  function automatic logic [3:0] ref_alu(bit rtype, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (rtype && f7) ? 4'b0001 : 4'b0000;
      3'd1: return 4'b1001;
      3'd2: return 4'b1101;
      3'd3: return 4'b1100;
      3'd4: return 4'b1000;
      3'd5: return f7 ? 4'b1011 : 4'b1010;
      3'd6: return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [6:0] kind_opcode(int k);
    case (k)
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push(bit rdy, bit z, outs_t o);
    cyc_t c;
    c.ready = rdy; c.zero = z; c.o = o;
    q.push_back(c);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle list for one instruction, fw/mw = memory wait cycles.
  task automatic build(int k, logic [2:0] f3, logic f7, bit z, int fw, int mw);
    outs_t o;
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.req = 1; o.sb = 2'b10; o.rs = 2'b10;
      o.ir = (i == fw); o.pcw = (i == fw);
      push(i == fw, rb(), o);
    end
    o = '0; o.sa = 2'b01; o.sb = 2'b01;
    o.imm = (k == K_STORE) ? 3'b001 : (k == K_BR) ? 3'b010 : (k == K_JAL) ? 3'b011 : 3'b000;
    push(rb(), rb(), o);
    if (k == K_LOAD || k == K_STORE) begin
      o = '0; o.sa = 2'b10; o.sb = 2'b01;
      push(rb(), rb(), o);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.req = 1; o.adr = 1; o.we = (k == K_STORE);
        push(i == mw, rb(), o);
      end
      if (k == K_LOAD) begin
        o = '0; o.rs = 2'b01; o.rw = 1;
        push(rb(), rb(), o);
      end
    end else if (k == K_R || k == K_I || k == K_JAL) begin
      o = '0;
      if (k == K_JAL) begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1; end
      else begin o.sa = 2'b10; o.sb = (k == K_I) ? 2'b01 : 2'b00; o.alu = ref_alu(k == K_R, f3, f7); end
      push(rb(), rb(), o);
      o = '0; o.rw = 1;
      push(rb(), rb(), o);
    end else if (k == K_BR) begin
      o = '0; o.sa = 2'b10; o.alu = 4'b0001;
      o.pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
      push(rb(), z, o);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        o = '0; o.ill = 1;
        push(rb(), rb(), o);
      end
`endif
    end
  endtask

  task automatic run_q(string tag, int n);
    int k = 0;
    cyc_t c;
    while (q.size() > 0 && k < n) begin
      c = q.pop_front();
      bus.mem_ready = c.ready;
      bus.zero      = c.zero;
      @(negedge clk);
      check($sformatf("%s.c%0d", tag, k), sample(), c.o);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic reset_cycles(string tag, int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rb();
      bus.zero      = rb();
      @(negedge clk);
      check($sformatf("%s.rst%0d", tag, i), sample(), outs_t'('0));
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic do_instr(string tag, int k, logic [2:0] f3, logic f7, bit z, int fw, int mw);
    int n;
    bus.opcode = kind_opcode(k); bus.funct3 = f3; bus.funct7b5 = f7;
    build(k, f3, f7, z, fw, mw);
    n = q.size();
    run_q(tag, n);
    $display("instr %s op=%b f3=%0d f7b5=%0d zero=%0d fw=%0d mw=%0d cycles=%0d",
             tag, bus.opcode, f3, f7, z, fw, mw, n);
`ifdef ILLEGAL_TRAP_EN
    if (k == K_ILL) reset_cycles({tag, ".trap"}, 1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    reset_cycles("init", 2);

    // reset during a stalled load read
    bus.opcode = kind_opcode(K_LOAD); bus.funct3 = 3'd2; bus.funct7b5 = 1'b0;
    build(K_LOAD, 3'd2, 1'b0, 1'b0, 0, 6);
    run_q("ldabort", 5);
    q.delete();
    reset_cycles("ldabort", 3);
    $display("instr ldabort reset held 3 cycles in MEMREAD");

    do_instr("sub",    K_R,   3'd0, 1'b1, 1'b0, 0, 0);
    do_instr("lw_w3",  K_LOAD, 3'd2, 1'b0, 1'b0, 0, 3);
    do_instr("beq_z1", K_BR,  3'd0, 1'b0, 1'b1, 0, 0);
    do_instr("bne_z1", K_BR,  3'd1, 1'b0, 1'b1, 0, 0);
    do_instr("bne_z0", K_BR,  3'd1, 1'b0, 1'b0, 0, 0);
    do_instr("srai",   K_I,   3'd5, 1'b1, 1'b0, 0, 0);
    do_instr("srli",   K_I,   3'd5, 1'b0, 1'b0, 0, 0);
    do_instr("addi7",  K_I,   3'd0, 1'b1, 1'b0, 0, 0);
    do_instr("sw",     K_STORE, 3'd2, 1'b0, 1'b0, 1, 2);
    do_instr("jal",    K_JAL, 3'd0, 1'b0, 1'b0, 2, 0);
    do_instr("ill",    K_ILL, 3'd0, 1'b0, 1'b0, 0, 0);
    do_instr("after_ill", K_R, 3'd7, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      do_instr($sformatf("rnd%0d", i), int'($urandom_range(0, 6)),
               3'($urandom_range(0, 7)), rb(), rb(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
